// File: rtl/rom_arbiter.sv
// Two-port (instruction fetch / data read) arbiter in front of a synchronous byte-wide ROM.
// Each grant reads 3 or 2 consecutive bytes one per cycle and returns them as a single response.
module rom_arbiter #(
  parameter int          SIZE    = 2048,
  parameter logic [15:0] ROMBASE = 16'h4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_ready,
  output logic [23:0] i_data,
  output logic        i_valid,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  output logic        d_ready,
  output logic [15:0] d_data,
  output logic        d_valid,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_e;

  state_e      state_q, state_d;
  logic        iPend_q, dPend_q;
  logic [15:0] iAddr_q, dAddr_q;
  logic        sel_q, sel_d;
  logic        lastGrant_q, lastGrant_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        capEn_q, capRd_q;
  logic [1:0]  capIdx_q;
  logic [23:0] buf_q, bufNext;
  logic [23:0] iData_q;
  logic [15:0] dData_q;

  logic        iXfer, dXfer;
  logic [15:0] selAddr, byteAddr, memOff;
  logic [1:0]  lastIdx;
  logic        inRange;
  logic [7:0]  capByte;

  assign i_ready  = !iPend_q;
  assign d_ready  = !dPend_q;
  assign iXfer    = i_req && !iPend_q;
  assign dXfer    = d_req && !dPend_q;
  assign i_data   = iData_q;
  assign d_data   = dData_q;
  assign i_valid  = (state_q == RESP) && !sel_q;
  assign d_valid  = (state_q == RESP) && sel_q;

  // sel_q = 1 means the data port owns the current transaction
  assign selAddr  = sel_q ? dAddr_q : iAddr_q;
  assign lastIdx  = sel_q ? 2'd1 : 2'd2;
  assign byteAddr = selAddr + {14'b0, cnt_q};
  assign memOff   = byteAddr - ROMBASE;
  assign inRange  = {1'b0, memOff} < 17'(SIZE);
  assign mem_addr = memOff;
  assign mem_rd   = (state_q == ISSUE) && inRange;

  // Out-of-range bytes were never read, so they are captured as zero
  assign capByte  = capRd_q ? mem_data : 8'h00;

  always_comb begin
    bufNext = buf_q;
    if (capEn_q) begin
      case (capIdx_q)
        2'd0:    bufNext[7:0]   = capByte;
        2'd1:    bufNext[15:8]  = capByte;
        default: bufNext[23:16] = capByte;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    lastGrant_d = lastGrant_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (iPend_q && dPend_q) begin
          sel_d = !lastGrant_q;
        end else if (iPend_q) begin
          sel_d = 1'b0;
        end else if (dPend_q) begin
          sel_d = 1'b1;
        end
        if (iPend_q || dPend_q) begin
          lastGrant_d = sel_d;
          cnt_d       = 2'd0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == lastIdx) begin
          cnt_d   = 2'd0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DRAIN:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      iPend_q     <= 1'b0;
      dPend_q     <= 1'b0;
      iAddr_q     <= 16'h0000;
      dAddr_q     <= 16'h0000;
      sel_q       <= 1'b0;
      lastGrant_q <= 1'b1;
      cnt_q       <= 2'd0;
      capEn_q     <= 1'b0;
      capRd_q     <= 1'b0;
      capIdx_q    <= 2'd0;
      buf_q       <= 24'h0;
      iData_q     <= 24'h0;
      dData_q     <= 16'h0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      lastGrant_q <= lastGrant_d;
      cnt_q       <= cnt_d;
      capEn_q     <= (state_q == ISSUE);
      capRd_q     <= mem_rd;
      capIdx_q    <= cnt_q;
      buf_q       <= bufNext;
      if (iXfer) begin
        iPend_q <= 1'b1;
        iAddr_q <= i_addr;
      end else if (i_valid) begin
        iPend_q <= 1'b0;
      end
      if (dXfer) begin
        dPend_q <= 1'b1;
        dAddr_q <= d_addr;
      end else if (d_valid) begin
        dPend_q <= 1'b0;
      end
      // The final byte lands during DRAIN, so the response is built from bufNext
      if (state_q == DRAIN) begin
        if (sel_q) dData_q <= bufNext[15:0];
        else       iData_q <= bufNext;
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: single transactions from a vector table, then
// tie-break, busy-port, back-to-back and mid-transaction reset sequences.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0;
  logic [15:0] i_addr = 16'h0, d_addr = 16'h0;
  logic        i_ready, i_valid, d_ready, d_valid, mem_rd;
  logic [23:0] i_data;
  logic [15:0] d_data, mem_addr;
  logic [7:0]  mem_data = 8'hCC;

  logic [7:0]  rom [0:65535];
  int          nChecks = 0;
  int          nFail = 0;
  logic [23:0] lastI;
  logic [15:0] lastD;

  typedef struct {
    logic        isData;
    logic [15:0] addr;
    logic [23:0] expData;
    logic [2:0]  rdMask;
  } vec_t;

  vec_t vecs [6];

  rom_arbiter #(.SIZE(2048), .ROMBASE(16'h4000)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_data(i_data), .i_valid(i_valid),
    .d_req(d_req), .d_addr(d_addr), .d_ready(d_ready), .d_data(d_data), .d_valid(d_valid),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Synchronous ROM model; a non-read cycle drives a marker so stray captures show up
  always @(posedge clk) begin
    if (mem_rd) mem_data <= rom[mem_addr];
    else        mem_data <= 8'hCC;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // One transfer in T0 from an idle arbiter, then cycle-by-cycle checks through T(N+4)
  task automatic applyStimulus(input vec_t v);
    int n;
    logic [15:0] expOff;
    n = v.isData ? 2 : 3;
    @(negedge clk);
    if (v.isData) begin d_req = 1'b1; d_addr = v.addr; end
    else          begin i_req = 1'b1; i_addr = v.addr; end
    checkOutput("ready T0", v.isData ? d_ready : i_ready, 1);
    for (int t = 1; t <= n + 4; t++) begin
      @(negedge clk);
      if (t == 1) begin i_req = 1'b0; d_req = 1'b0; end
      if (t >= 2 && t <= n + 1) begin
        checkOutput($sformatf("mem_rd T%0d addr %h", t, v.addr), mem_rd, v.rdMask[t-2]);
        if (v.rdMask[t-2]) begin
          expOff = v.addr + 16'(t - 2) - 16'h4000;
          checkOutput($sformatf("mem_addr T%0d addr %h", t, v.addr), mem_addr, expOff);
        end
      end else begin
        checkOutput($sformatf("mem_rd idle T%0d addr %h", t, v.addr), mem_rd, 0);
      end
      checkOutput($sformatf("valid T%0d addr %h", t, v.addr), v.isData ? d_valid : i_valid, t == n + 3);
      checkOutput($sformatf("other valid T%0d", t), v.isData ? i_valid : d_valid, 0);
      checkOutput($sformatf("ready T%0d addr %h", t, v.addr), v.isData ? d_ready : i_ready, t == n + 4);
      if (t == n + 3) begin
        if (v.isData) begin
          checkOutput($sformatf("d_data addr %h", v.addr), d_data, v.expData[15:0]);
          checkOutput("i_data hold", i_data, lastI);
        end else begin
          checkOutput($sformatf("i_data addr %h", v.addr), i_data, v.expData);
          checkOutput("d_data hold", d_data, lastD);
        end
      end
    end
    if (v.isData) lastD = v.expData[15:0];
    else          lastI = v.expData;
  endtask

  initial begin
    logic        order [$];
    logic [15:0] off;
    for (int i = 0; i < 65536; i++) begin
      off = 16'(i);
      rom[i] = off[7:0] ^ 8'hA5;
    end
    rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33;
    rom[16] = 8'h44; rom[17] = 8'h55;
    rom[2046] = 8'h66; rom[2047] = 8'h77;

    vecs[0] = '{1'b0, 16'h4000, 24'h332211, 3'b111};
    vecs[1] = '{1'b1, 16'h4010, 24'h005544, 3'b011};
    vecs[2] = '{1'b1, 16'h47FF, 24'h000077, 3'b001};
    vecs[3] = '{1'b0, 16'h3FFF, 24'h221100, 3'b110};
    vecs[4] = '{1'b1, 16'hFFFF, 24'h000000, 3'b000};
    vecs[5] = '{1'b0, 16'h47FE, 24'h007766, 3'b011};

    #2;
    checkOutput("reset i_ready", i_ready, 1);
    checkOutput("reset d_ready", d_ready, 1);
    checkOutput("reset i_valid", i_valid, 0);
    checkOutput("reset d_valid", d_valid, 0);
    checkOutput("reset mem_rd", mem_rd, 0);
    checkOutput("reset i_data", i_data, 0);
    checkOutput("reset d_data", d_data, 0);
    lastI = 24'h0;
    lastD = 16'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 6; k++) applyStimulus(vecs[k]);

    // Tie with the last grant on fetch: data goes first
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h4000;
    d_req = 1'b1; d_addr = 16'h4000;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      if (t == 1) begin i_req = 1'b0; d_req = 1'b0; end
      checkOutput($sformatf("tie2 d_valid T%0d", t), d_valid, t == 5);
      checkOutput($sformatf("tie2 i_valid T%0d", t), i_valid, t == 11);
      if (t == 5)  checkOutput("tie2 d_data", d_data, 16'h2211);
      if (t == 11) checkOutput("tie2 i_data", i_data, 24'h332211);
    end

    // Tie right after reset: fetch first; requests on busy ports are ignored
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h4000;
    d_req = 1'b1; d_addr = 16'h4010;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      checkOutput($sformatf("tie i_valid T%0d", t), i_valid, t == 6);
      checkOutput($sformatf("tie d_valid T%0d", t), d_valid, t == 11);
      checkOutput($sformatf("tie mem_rd T%0d", t), mem_rd, (t >= 2 && t <= 4) || (t >= 8 && t <= 9));
      checkOutput($sformatf("tie d_ready T%0d", t), d_ready, t >= 12);
      if (t == 8)  checkOutput("tie data mem_addr", mem_addr, 16'h0010);
      if (t == 6)  checkOutput("tie i_data", i_data, 24'h332211);
      if (t == 11) begin
        checkOutput("tie d_data", d_data, 16'h5544);
        checkOutput("tie i_data hold", i_data, 24'h332211);
      end
      if (t == 1) begin i_addr = 16'hFFFF; d_addr = 16'hFFFF; end
      if (t == 3) i_req = 1'b0;
      if (t == 5) d_req = 1'b0;
    end

    // Both ports held requesting: grants alternate starting with fetch
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h4000;
    d_req = 1'b1; d_addr = 16'h47FF;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (i_valid) begin
        order.push_back(1'b0);
        checkOutput("rr i_data", i_data, 24'h332211);
      end
      if (d_valid) begin
        order.push_back(1'b1);
        checkOutput("rr d_data", d_data, 16'h0077);
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    checkOutput("rr grant count", order.size() >= 6, 1);
    for (int k = 0; k < order.size(); k++)
      checkOutput($sformatf("rr order %0d", k), order[k], k % 2);
    repeat (20) @(negedge clk);

    // Reset during the ISSUE phase of a fetch
    i_req = 1'b1; i_addr = 16'h4000;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      if (t == 1) i_req = 1'b0;
    end
    checkOutput("mid mem_rd before reset", mem_rd, 1);
    reset = 1'b1;
    #1;
    checkOutput("mid mem_rd async", mem_rd, 0);
    checkOutput("mid i_ready async", i_ready, 1);
    checkOutput("mid i_data async", i_data, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      checkOutput($sformatf("mid no i_valid %0d", t), i_valid, 0);
      checkOutput($sformatf("mid no mem_rd %0d", t), mem_rd, 0);
    end
    lastD = 16'h0;
    applyStimulus(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 The block SHALL have parameter SIZE, default 2048, meaning the ROM window size in bytes.
REQ-002 The block SHALL have parameter ROMBASE, 16 bits, default 16'h4000, meaning the byte address of ROM offset 0.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_req  input  1  instruction-fetch request; transfers when i_req && i_ready.
REQ-006 i_addr  input  16  instruction byte address, sampled on transfer.
REQ-007 i_ready  output  1  fetch port can accept a request.
REQ-008 i_data  output  24  fetched bytes: {byte a+2, byte a+1, byte a}.
REQ-009 i_valid  output  1  one-cycle pulse; i_data valid.
REQ-010 d_req, d_addr, d_ready  input 1 / input 16 / output 1  data-read port; same handshake as the fetch port.
REQ-011 d_data  output  16  {byte a+1, byte a}.
REQ-012 d_valid  output  1  one-cycle pulse; d_data valid.
REQ-013 mem_rd  output  1  byte read strobe to the synchronous byte-wide ROM.
REQ-014 mem_addr  output  16  ROM offset, already rebased by subtracting ROMBASE.
REQ-015 mem_data  input  8  ROM byte, valid the cycle after mem_rd.

Function
REQ-016 Per-port pending flag: set on transfer, cleared in that port's valid cycle; ready = !pending, so ready rises the cycle after valid.
REQ-017 The block SHALL ignore a request while ready=0 and leave the latched address unchanged.
REQ-018 FSM states: IDLE, ISSUE, DRAIN, RESP.
REQ-019 IDLE -> ISSUE when any pending: select the port and byte count N (fetch 3, data 2).
REQ-020 ISSUE lasts exactly N cycles; byte k=0..N-1 is issued on successive cycles; ISSUE -> DRAIN after byte N-1.
REQ-021 DRAIN lasts 1 cycle, capturing the last byte; DRAIN -> RESP.
REQ-022 RESP lasts 1 cycle with that port's valid=1; RESP -> IDLE.
REQ-023 Byte k address = (addr + k) mod 2^16; mem_addr = (addr + k - ROMBASE) mod 2^16.
REQ-024 In range iff (addr + k - ROMBASE) mod 2^16 < SIZE.
REQ-025 In-range byte: mem_rd=1 and the byte is taken from mem_data the following cycle.
REQ-026 Out-of-range byte: mem_rd=0 and the byte is captured as 8'h00.
REQ-027 mem_rd SHALL be 0 outside ISSUE; mem_addr is don't-care when mem_rd=0.
REQ-028 Timing with transfer in cycle T0 and an idle FSM: IDLE T1, ISSUE T2..T(N+1), valid in T(N+3) (fetch T6, data T5), IDLE T(N+4).
REQ-029 Tie in IDLE: round-robin, granting the port not granted last; last_grant is updated on every grant.
REQ-030 A single pending port is granted regardless of last_grant.
REQ-031 i_data/d_data SHALL hold their last value until the next valid for that port.
REQ-032 A request arriving during another port's transaction waits; no transaction is ever interleaved.

Reset
REQ-033 Reset SHALL immediately force state=IDLE, both pending=0, i_ready=d_ready=1, i_valid=d_valid=0, mem_rd=0, i_data=0, d_data=0, last_grant=data (so fetch wins the first tie).
REQ-034 Reset mid-transaction SHALL discard the transaction with no valid pulse; operation resumes with the first transfer after reset deasserts.

Verification
REQ-035 ROM[0..2]=11,22,33; fetch i_addr=16'h4000 accepted at T0 -> mem_rd T2..T4 with mem_addr 0,1,2; i_valid only in T6; i_data=24'h332211.
REQ-036 Both ports request in the same cycle after reset (i_addr=4000, d_addr=4010) -> fetch served first (i_valid T6); data mem_rd starts T8; d_valid T11.
REQ-037 Out of range: d_addr=16'h47FF with SIZE=2048 -> mem_rd only for offset 7FF; d_data={8'h00, ROM[7FF]}. i_addr=16'h3FFF -> byte0=00, bytes 1-2 from offsets 0,1.
REQ-038 Wrap-around: d_addr=16'hFFFF -> second byte address 16'h0000; both bytes out of range; d_data=16'h0000; mem_rd never asserted.
REQ-039 Both ports held requesting continuously -> grants alternate fetch, data, fetch...; i_req while i_ready=0 is ignored.
REQ-040 reset asserted during ISSUE of a fetch -> mem_rd drops asynchronously; no i_valid; a new fetch after reset returns correct data with REQ-028 timing.
